// File: rtl/shift_rotate_stage.sv
// Rotator stage for the shift/rotate unit. It rotates the operand left or
// right and registers the result together with the control fields. All
// zero-fill and sign-fill is left to the downstream masker.
// The valid/ready handshake is a plain pipeline register with skid-free
// back-pressure.
// Optional build macro: SHIFT_ROTATE_SPLIT_EN splits the rotate across two
// registers. Stage A rotates by the amount with bits [1:0] cleared, and
// stage B rotates by bits [1:0]. Latency is 2 cycles instead of 1.
module shift_rotate_stage #(
  parameter  int BitWidth = 32,
  localparam int AmtW     = $clog2(BitWidth)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [BitWidth-1:0] in_data,
  input  logic [AmtW-1:0]     in_amount,
  input  logic                in_arith,
  input  logic                in_left,
  input  logic                in_shift,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [BitWidth-1:0] out_rotated,
  output logic [AmtW-1:0]     out_amount,
  output logic                out_sign,
  output logic                out_arith,
  output logic                out_left,
  output logic                out_shift
);

  typedef struct packed {
    logic [BitWidth-1:0] data;
    logic [AmtW-1:0]     amount;
    logic                sign;
    logic                arith;
    logic                left;
    logic                shift;
  } payload_t;

  // Doubled-operand rotate: the wrapped bits come for free from the copy.
  function automatic logic [BitWidth-1:0] f_rot(
    input logic [BitWidth-1:0] d,
    input logic [AmtW-1:0]     amt,
    input logic                left
  );
    logic [2*BitWidth-1:0] t;
    if (left) begin
      t = {d, d} << amt;
      return t[2*BitWidth-1:BitWidth];
    end
    t = {d, d} >> amt;
    return t[BitWidth-1:0];
  endfunction

  payload_t w_pl_in;
  payload_t r_pl_last;
  logic     r_vld_last;

`ifdef SHIFT_ROTATE_SPLIT_EN
  payload_t r_pl_a;
  logic     r_vld_a;
  logic     w_adv_a;
  logic     w_adv_b;
  payload_t w_pl_b;

  // Each register moves when it is empty or when its successor is moving.
  assign w_adv_b  = ~r_vld_last | out_ready;
  assign w_adv_a  = ~r_vld_a | w_adv_b;
  assign in_ready = w_adv_a;

  // Stage A does the coarse rotate, in multiples of 4.
  always_comb begin
    w_pl_in        = '0;
    w_pl_in.data   = f_rot(in_data, {in_amount[AmtW-1:2], 2'b00}, in_left);
    w_pl_in.amount = in_amount;
    w_pl_in.sign   = in_data[BitWidth-1];
    w_pl_in.arith  = in_arith;
    w_pl_in.left   = in_left;
    w_pl_in.shift  = in_shift;
  end

  // Stage B finishes the rotate using the low two amount bits.
  always_comb begin
    w_pl_b      = r_pl_a;
    w_pl_b.data = f_rot(r_pl_a.data, {{(AmtW-2){1'b0}}, r_pl_a.amount[1:0]},
                        r_pl_a.left);
  end

  // Stage A register. The payload loads only when a valid operation enters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld_a <= 1'b0;
      r_pl_a  <= '0;
    end else if (w_adv_a) begin
      r_vld_a <= in_valid;
      if (in_valid) r_pl_a <= w_pl_in;
    end
  end

  // Stage B register, which drives the outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld_last <= 1'b0;
      r_pl_last  <= '0;
    end else if (w_adv_b) begin
      r_vld_last <= r_vld_a;
      if (r_vld_a) r_pl_last <= w_pl_b;
    end
  end
`else
  // A single register. It accepts new data when empty or draining this cycle.
  assign in_ready = ~r_vld_last | out_ready;

  // Full rotate in one step, with the sign captured before rotation.
  always_comb begin
    w_pl_in        = '0;
    w_pl_in.data   = f_rot(in_data, in_amount, in_left);
    w_pl_in.amount = in_amount;
    w_pl_in.sign   = in_data[BitWidth-1];
    w_pl_in.arith  = in_arith;
    w_pl_in.left   = in_left;
    w_pl_in.shift  = in_shift;
  end

  // Output register. A simultaneous drain and fill replaces the contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld_last <= 1'b0;
      r_pl_last  <= '0;
    end else if (in_ready) begin
      r_vld_last <= in_valid;
      if (in_valid) r_pl_last <= w_pl_in;
    end
  end
`endif

  assign out_valid   = r_vld_last;
  assign out_rotated = r_pl_last.data;
  assign out_amount  = r_pl_last.amount;
  assign out_sign    = r_pl_last.sign;
  assign out_arith   = r_pl_last.arith;
  assign out_left    = r_pl_last.left;
  assign out_shift   = r_pl_last.shift;

endmodule

// File: tb/tb_shift_rotate_stage.sv
// Directed bench for shift_rotate_stage (BitWidth=32), with hand-computed
// expected values. Inputs change 1 time unit after the rising edge, and
// outputs are sampled on the falling edge.
module tb_shift_rotate_stage;
`ifdef SHIFT_ROTATE_SPLIT_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk, rst;
  logic        in_valid, in_ready, in_arith, in_left, in_shift;
  logic [31:0] in_data;
  logic [4:0]  in_amount;
  logic        out_valid, out_ready, out_sign, out_arith, out_left, out_shift;
  logic [31:0] out_rotated;
  logic [4:0]  out_amount;

  int n_chk, n_err;
  logic acc;

  shift_rotate_stage #(.BitWidth(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_amount(in_amount), .in_arith(in_arith), .in_left(in_left),
    .in_shift(in_shift), .out_valid(out_valid), .out_ready(out_ready),
    .out_rotated(out_rotated), .out_amount(out_amount), .out_sign(out_sign),
    .out_arith(out_arith), .out_left(out_left), .out_shift(out_shift)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic smp();
    @(negedge clk);
    acc = in_valid & in_ready;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] d, input logic [4:0] a,
                       input logic ar, input logic l, input logic s);
    in_valid  = 1'b1;
    in_data   = d;
    in_amount = a;
    in_arith  = ar;
    in_left   = l;
    in_shift  = s;
  endtask

  // Sends one operation with out_ready high, then checks latency and every field.
  task automatic run_op(input string tag, input logic [31:0] d, input logic [4:0] a,
                        input logic ar, input logic l, input logic s,
                        input logic [31:0] exp_rot);
    int  lat;
    bit  got;
    out_ready = 1'b1;
    drive(d, a, ar, l, s);
    smp();
    check({tag, "_acc"}, acc, 1);
    step();
    in_valid = 1'b0;
    lat = 0;
    got = 0;
    while (!got && lat < 8) begin
      smp();
      lat++;
      if (out_valid) got = 1;
      else step();
    end
    check({tag, "_lat"}, lat, LAT);
    check({tag, "_rot"}, out_rotated, exp_rot);
    check({tag, "_amt"}, out_amount, a);
    check({tag, "_sign"}, out_sign, d[31]);
    check({tag, "_ctl"}, {out_arith, out_left, out_shift}, {ar, l, s});
    step();
    smp();
    check({tag, "_drain"}, out_valid, 0);
    step();
  endtask

  logic [31:0] b2b_exp [3];
  logic [4:0]  b2b_amt [3];
  int          b2b_cyc [3];

  initial begin
    int k, r, n;
    bit got;
    n_chk = 0; n_err = 0; acc = 0;
    rst = 1'b1; in_valid = 0; in_data = 0; in_amount = 0;
    in_arith = 0; in_left = 0; in_shift = 0; out_ready = 0;

    // Reset values.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_valid", out_valid, 0);
    check("rst_payload", {out_rotated, out_amount, out_sign, out_arith, out_left, out_shift}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    smp();
    check("post_rst_ready", in_ready, 1);
    step();

    // Basic rotates.
    run_op("rotl4", 32'h8000_0001, 5'd4, 1'b0, 1'b1, 1'b0, 32'h0000_0018);
    run_op("rotr8", 32'h1234_5678, 5'd8, 1'b1, 1'b0, 1'b1, 32'h7812_3456);
    run_op("rotr7", 32'h0000_0080, 5'd7, 1'b0, 1'b0, 1'b0, 32'h0000_0001);

    // Back-pressure: hold out_ready low and offer a second operation.
    out_ready = 1'b0;
    drive(32'hDEAD_BEEF, 5'd12, 1'b0, 1'b0, 1'b0);
    smp();
    check("bp_acc1", acc, 1);
    step();
    drive(32'h0000_FFFF, 5'd16, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      smp();
      if (out_valid) begin
        check("bp_hold_rot", out_rotated, 32'hEEFD_EADB);
        check("bp_hold_amt", out_amount, 5'd12);
      end
      step();
      if (acc) in_valid = 1'b0;
    end
    smp();
    check("bp_full_ready", in_ready, 0);
    check("bp_full_valid", out_valid, 1);
    check("bp_full_rot", out_rotated, 32'hEEFD_EADB);
    step();
    out_ready = 1'b1;
    smp();
    check("bp_rel_rot", out_rotated, 32'hEEFD_EADB);
    step();
    if (acc) in_valid = 1'b0;
    smp();
    check("bp_op2_valid", out_valid, 1);
    check("bp_op2_rot", out_rotated, 32'hFFFF_0000);
    check("bp_op2_ctl", {out_left, out_shift}, 2'b11);
    step();
    in_valid = 1'b0;
    smp();
    check("bp_drain", out_valid, 0);
    step();

    // Back-to-back amounts 0, 1 and 31 at full throughput.
    b2b_amt[0] = 5'd0;  b2b_exp[0] = 32'h8000_0003;
    b2b_amt[1] = 5'd1;  b2b_exp[1] = 32'h0000_0007;
    b2b_amt[2] = 5'd31; b2b_exp[2] = 32'hC000_0001;
    out_ready = 1'b1;
    drive(32'h8000_0003, b2b_amt[0], 1'b1, 1'b1, 1'b1);
    k = 1; r = 0;
    for (int c = 0; c < 10; c++) begin
      smp();
      if (out_valid) begin
        if (r < 3) begin
          check($sformatf("b2b_rot%0d", r), out_rotated, b2b_exp[r]);
          check($sformatf("b2b_amt%0d", r), out_amount, b2b_amt[r]);
          b2b_cyc[r] = c;
        end
        r++;
      end
      step();
      if (acc) begin
        if (k < 3) begin
          drive(32'h8000_0003, b2b_amt[k], 1'b1, 1'b1, 1'b1);
          k++;
        end else in_valid = 1'b0;
      end
    end
    check("b2b_count", r, 3);
    check("b2b_consec1", b2b_cyc[1] - b2b_cyc[0], 1);
    check("b2b_consec2", b2b_cyc[2] - b2b_cyc[0], 2);

    // Asynchronous reset mid-cycle while a result is held.
    out_ready = 1'b0;
    drive(32'hFFFF_0000, 5'd5, 1'b1, 1'b1, 1'b1);
    smp();
    step();
    in_valid = 1'b0;
    got = 0; n = 0;
    while (!got && n < 4) begin
      smp();
      n++;
      if (out_valid) got = 1;
      else step();
    end
    check("arst_pre_valid", out_valid, 1);
    check("arst_pre_rot", out_rotated, 32'hFFE0_001F);
    #2;
    rst = 1'b1;
    #1;
    check("arst_valid", out_valid, 0);
    check("arst_payload", {out_rotated, out_amount, out_sign, out_arith, out_left, out_shift}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    smp();
    check("arst_ready", in_ready, 1);
    check("arst_no_valid", out_valid, 0);
    step();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      smp();
      check("arst_discard", out_valid, 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/shift_rotate_stage.md
SHIFT_ROTATE_STAGE -- requirements
Module: shift_rotate_stage

Interface
REQ-001 SHALL have parameter BitWidth, default 32: data width; power of two, >= 8.
REQ-002 SHALL have port clk  input  1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1: reset, asynchronous and active-high.
REQ-004 SHALL have port in_valid  input  1: upstream offers an operation.
REQ-005 SHALL have port in_ready  output  1: stage accepts the operation this cycle.
REQ-006 SHALL have port in_data  input  BitWidth: operand to shift or rotate.
REQ-007 SHALL have port in_amount  input  $clog2(BitWidth): shift/rotate amount.
REQ-008 SHALL have ports in_arith, in_left, in_shift  input  1 each: arith1_logic0, left1_right0, shift1_rotate0.
REQ-009 SHALL have port out_valid  output  1: rotated result available to the masker.
REQ-010 SHALL have port out_ready  input  1: masker stage consumes the result.
REQ-011 SHALL have port out_rotated  output  BitWidth: in_data rotated per in_left by in_amount.
REQ-012 SHALL have port out_amount  output  $clog2(BitWidth): registered copy of in_amount.
REQ-013 SHALL have port out_sign  output  1: registered in_data[BitWidth-1], taken before rotation.
REQ-014 SHALL have ports out_arith, out_left, out_shift  output  1 each: registered copies of the control inputs.

Function
REQ-015 SHALL transfer on the input side when in_valid & in_ready, and on the output side when out_valid & out_ready.
REQ-016 SHALL rotate left by in_amount when in_left=1, otherwise rotate right by in_amount; amount 0 passes data unchanged, regardless of in_shift and in_arith.
REQ-017 SHALL NOT mask, zero-fill or sign-fill any bit; all fill is left to the downstream masker.
REQ-018 SHALL hold each pipeline register as a payload register plus a valid bit.
REQ-019 SHALL drive in_ready = ~v_last | out_ready when unsplit, where v_last is the valid bit of the output register.
REQ-020 SHALL advance each register when it is empty or its successor is advancing.
REQ-021 SHALL keep all out_* payload bits stable while out_valid=1 and out_ready=0.
REQ-022 SHALL never drop out_valid without a completed output transfer.
REQ-023 SHALL sustain one transfer per cycle when out_ready is held 1.
REQ-024 SHALL, on a simultaneous output transfer and input transfer into a full register, replace the contents with no bubble.
REQ-025 SHALL keep payload registers unchanged when no advance occurs; no combinational path from in_data to out_rotated.

Reset
REQ-026 SHALL, while rst=1 and regardless of clk, force all valid bits to 0, so out_valid=0.
REQ-027 SHALL, while rst=1, force out_rotated, out_amount, out_sign, out_arith, out_left and out_shift to 0.
REQ-028 SHALL hold in_ready=1 after reset.
REQ-029 SHALL discard any operation in flight when rst asserts mid-operation.
REQ-030 SHALL produce no output transfer for a discarded operation.

Configuration
REQ-031 SHALL, with macro SHIFT_ROTATE_SPLIT_EN defined, use two registers:
- stage A rotates by in_amount with bits [1:0] forced to 0;
- stage B rotates the stage A result by in_amount[1:0].
REQ-032 SHALL, with SHIFT_ROTATE_SPLIT_EN defined, have 2-cycle latency, full throughput and ready propagated per REQ-020.
REQ-033 SHALL, without SHIFT_ROTATE_SPLIT_EN, use a single register with 1-cycle latency from input transfer to out_valid.
REQ-034 SHALL present identical out_* values and transfer order in both configurations.

Verification
REQ-035 SHALL cover: BitWidth=32, in_data=0x80000001, amount=4, left=1, out_ready=1 -> next cycle out_valid=1, out_rotated=0x00000018, out_sign=1.
REQ-036 SHALL cover: in_data=0x12345678, amount=8, left=0, shift=1, arith=1 -> out_rotated=0x78123456, out_sign=0, out_arith=1, out_shift=1.
REQ-037 SHALL cover: out_ready=0 for 5 cycles after one transfer -> in_ready=0 once full, out_* constant, then a single transfer when out_ready=1.
REQ-038 SHALL cover: back-to-back amounts 0,1,31 with out_ready=1 -> three results on consecutive cycles; amount 0 gives in_data unchanged.
REQ-039 SHALL cover: rst pulsed mid-clock while out_valid=1 -> out_valid=0 and all payload outputs 0 immediately, in_ready=1 after release.
REQ-040 SHALL cover: SHIFT_ROTATE_SPLIT_EN defined, amount=7, left=0, in_data=0x00000080 -> out_rotated=0x00000001 two cycles after acceptance.
